uart_tx_frame_serializer: RTL and testbench

Parametrised UART transmit frame engine for the UART_TX path. It accepts one parallel word per handshake and serialises it LSB-first as a complete frame: start bit, data, optional parity, and one or two stop bits. It supports runtime-selectable parity modes (even, odd, stick-0, stick-1) and back-to-back frames without idle gaps. CLK is the TX bit-rate clock, so one frame bit is sent per CLK cycle.

---
 rtl/uart_tx_frame_serializer.sv | 116 +++++++++++
 tb/tb_uart_tx_frame_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit frame engine: one parallel word per handshake, sent LSB-first as
// start / data / optional parity / one or two stop bits, one bit per CLK.
module uart_tx_frame_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic [1:0]            PAR_TYP,
  input  logic                  STOP2,
  output logic                  READY,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  FRAME_DONE
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  par_en;
    logic [1:0]            par_typ;
    logic                  stop2;
  } frame_cfg_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  frame_cfg_t       cfg, cfg_nxt;
  logic             final_stop, accept, par, tx_nxt, done_nxt;

  // Final stop cycle is the only point inside a frame where a new word may land.
  always_comb begin
    final_stop = (state == S_STOP2) || (state == S_STOP1 && !cfg.stop2);
    READY      = (state == S_IDLE) || final_stop;
    accept     = DATA_VALID && READY;
  end

  always_comb begin
    cfg_nxt = cfg;
    if (accept) begin
      cfg_nxt.data    = P_DATA;
      cfg_nxt.par_en  = PAR_EN;
      cfg_nxt.par_typ = PAR_TYP;
      cfg_nxt.stop2   = STOP2;
    end
  end

  // par_typ[1] selects stick mode, where par_typ[0] is the bit itself;
  // otherwise par_typ[0] flips even into odd.
  always_comb begin
    if (cfg.par_typ[1]) par = cfg.par_typ[0];
    else                par = (^cfg.data) ^ cfg.par_typ[0];
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_START;
      S_START: begin
        state_nxt = S_DATA;
        cnt_nxt   = '0;
      end
      S_DATA: begin
        if (cnt == LAST_BIT) state_nxt = cfg.par_en ? S_PARITY : S_STOP1;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      S_PARITY: state_nxt = S_STOP1;
      S_STOP1: begin
        if (cfg.stop2)   state_nxt = S_STOP2;
        else if (accept) state_nxt = S_START;
        else             state_nxt = S_IDLE;
      end
      S_STOP2:  state_nxt = accept ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Line level is decoded from the next state so TX_OUT comes straight off a flop.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = cfg.data[cnt_nxt];
      S_PARITY: tx_nxt = par;
      default:  tx_nxt = 1'b1;
    endcase
    done_nxt = (state_nxt == S_STOP2) || (state_nxt == S_STOP1 && !cfg.stop2);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cfg        <= '0;
      TX_OUT     <= 1'b1;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cfg        <= cfg_nxt;
      TX_OUT     <= tx_nxt;
      BUSY       <= (state_nxt != S_IDLE);
      FRAME_DONE <= done_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Scoreboard bench: a frame model pushes the per-cycle line image on acceptance,
// and a monitor pops one entry per cycle and compares the DUT outputs.
module tb_uart_tx_frame_serializer;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID, PAR_EN, STOP2;
  logic [1:0]    PAR_TYP;
  logic          READY, TX_OUT, BUSY, FRAME_DONE;

  logic [4:0] d5_data;
  logic       d5_valid;
  logic       d5_ready, d5_tx, d5_busy, d5_done;

  uart_tx_frame_serializer #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
    .READY(READY), .TX_OUT(TX_OUT), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
  );

  uart_tx_frame_serializer #(.DATA_WIDTH(5)) dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(d5_data), .DATA_VALID(d5_valid),
    .PAR_EN(1'b0), .PAR_TYP(2'b00), .STOP2(1'b0),
    .READY(d5_ready), .TX_OUT(d5_tx), .BUSY(d5_busy), .FRAME_DONE(d5_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic tx;
    logic done;
  } bit_t;

  bit_t exp_q[$];
  int   done_cyc[$];
  int   checks = 0, errors = 0, acc_cnt = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Whole-frame line image built straight from the frame format.
  function automatic void push_frame(input int data, input int w, input logic pe,
                                     input logic [1:0] pt, input logic s2);
    int   ones, nstop;
    bit_t e;
    ones   = 0;
    e.done = 1'b0;
    e.tx   = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < w; i++) begin
      e.tx = data[i];
      ones += int'(e.tx);
      exp_q.push_back(e);
    end
    if (pe) begin
      case (pt)
        2'b00:   e.tx = (ones % 2) == 1;
        2'b01:   e.tx = (ones % 2) == 0;
        2'b10:   e.tx = 1'b0;
        default: e.tx = 1'b1;
      endcase
      exp_q.push_back(e);
    end
    nstop = s2 ? 2 : 1;
    for (int j = 0; j < nstop; j++) begin
      e.tx   = 1'b1;
      e.done = (j == nstop - 1);
      exp_q.push_back(e);
    end
  endfunction

  // A word is taken only when no frame bits remain beyond the current cycle.
  always @(posedge CLK) begin
    if (RST && DATA_VALID && exp_q.size() == 0) begin
      push_frame(int'(P_DATA), DW, PAR_EN, PAR_TYP, STOP2);
      acc_cnt++;
    end
  end

  always @(negedge RST) exp_q.delete();

  always @(negedge CLK) begin : monitor
    bit_t e;
    cyc++;
    if (!RST || exp_q.size() == 0) begin
      check("idle_tx", TX_OUT, 1);
      check("idle_busy", BUSY, 0);
      check("idle_done", FRAME_DONE, 0);
      check("idle_ready", READY, 1);
    end else begin
      e = exp_q.pop_front();
      check("frame_tx", TX_OUT, e.tx);
      check("frame_busy", BUSY, 1);
      check("frame_done", FRAME_DONE, e.done);
      check("frame_ready", READY, e.done);
    end
    if (FRAME_DONE === 1'b1) done_cyc.push_back(cyc);
  end

  // Called at a negedge; returns at the negedge just after the accepting edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic [1:0] pt, input logic s2);
    int start, n;
    start      = acc_cnt;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    STOP2      = s2;
    DATA_VALID = 1'b1;
    n          = 0;
    while (acc_cnt == start && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (acc_cnt == start) timeout("accept");
  endtask

  task automatic idle_wait();
    int n;
    DATA_VALID = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) timeout("drain");
    @(negedge CLK);
  endtask

  initial begin
    logic [6:0] exp5;
    int         nd;
    RST = 1'b0; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 2'b00; STOP2 = 1'b0;
    d5_data = '0; d5_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_tx", TX_OUT, 1);
    check("rst_busy", BUSY, 0);
    check("rst_ready", READY, 1);
    RST = 1'b1;
    @(negedge CLK);

    send(8'hA5, 1'b1, 2'b00, 1'b0); idle_wait();
    send(8'h07, 1'b1, 2'b01, 1'b1); idle_wait();
    send(8'h07, 1'b1, 2'b11, 1'b1); idle_wait();
    send(8'h07, 1'b1, 2'b10, 1'b1); idle_wait();
    send(8'h3C, 1'b0, 2'b00, 1'b0); idle_wait();

    // Back-to-back with DATA_VALID held high throughout.
    send(8'h00, 1'b1, 2'b00, 1'b0);
    send(8'hFF, 1'b1, 2'b00, 1'b0);
    idle_wait();
    nd = done_cyc.size();
    if (nd >= 2) check("done_spacing", done_cyc[nd-1] - done_cyc[nd-2], 11);
    else timeout("done_pulses");

    // New word and parity type offered mid-frame must wait for READY.
    send(8'h5A, 1'b1, 2'b00, 1'b0);
    repeat (3) @(negedge CLK);
    send(8'h33, 1'b1, 2'b01, 1'b0);
    idle_wait();

    // Five-bit build, no parity, one stop: 0x13.
    exp5 = 7'b1100110;
    d5_data  = 5'h13;
    d5_valid = 1'b1;
    @(negedge CLK);
    d5_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("w5_tx", d5_tx, exp5[i]);
      check("w5_busy", d5_busy, 1);
      check("w5_done", d5_done, i == 6);
      @(negedge CLK);
    end
    check("w5_idle_tx", d5_tx, 1);
    check("w5_idle_busy", d5_busy, 0);
    check("w5_ready", d5_ready, 1);

    // Reset while data bit 3 of 0xC3 (a 0) is on the line.
    send(8'hC3, 1'b1, 2'b00, 1'b0);
    DATA_VALID = 1'b0;
    repeat (4) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("mid_rst_tx", TX_OUT, 1);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_done", FRAME_DONE, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    send(8'h55, 1'b1, 2'b00, 1'b0);
    idle_wait();

    // Random traffic: valid toggles freely, including while a frame is in flight.
    for (int c = 0; c < 600; c++) begin
      DATA_VALID = ($urandom_range(0, 1) == 1);
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 2'($urandom);
      STOP2      = 1'($urandom);
      @(negedge CLK);
    end
    idle_wait();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
